// File: rtl/mario_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mario_sample_scheduler
// Purpose  : Paces three analog-sound sample channels (Mario run, Luigi run,
//            skid) with a sample-rate divider and arbitrates one wave-ROM
//            fetch per active channel per sample period. Produces three
//            signed, volume-scaled 16-bit streams for the sound mixer.
// Options  : `MARIO_SAMPLE_LOOP_EN - when defined, a channel whose control bit
//            is still high at its end address wraps to its start address
//            instead of stopping.
// Revision : 1.0 - initial release
// ============================================================================
module mario_sample_scheduler #(
  parameter int                SAMPLE_DIV = 1088,
  parameter int                ROM_AW     = 16,
  parameter logic [ROM_AW-1:0] CH0_START  = 16'h0000,
  parameter logic [ROM_AW-1:0] CH0_END    = 16'h0FFF,
  parameter logic [ROM_AW-1:0] CH1_START  = 16'h1000,
  parameter logic [ROM_AW-1:0] CH1_END    = 16'h1FFF,
  parameter logic [ROM_AW-1:0] CH2_START  = 16'h2000,
  parameter logic [ROM_AW-1:0] CH2_END    = 16'h2FFF
) (
  input  logic                     I_CLK_12M,
  input  logic                     I_RESETn,
  input  logic [2:0]               I_SND_CTRL,
  input  logic [3:0]               I_ANLG_VOL,
  output logic                     O_ROM_REQ,
  output logic [ROM_AW-1:0]        O_ROM_ADDR,
  input  logic                     I_ROM_ACK,
  input  logic [7:0]               I_ROM_DATA,
  output logic signed [15:0]       O_WAVROM_DS0,
  output logic signed [15:0]       O_WAVROM_DS1,
  output logic signed [15:0]       O_WAVROM_DS2,
  output logic [2:0]               O_ACTIVE,
  output logic                     O_OVERRUN
);

  localparam int                 c_div_w    = $clog2(SAMPLE_DIV);
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SAMPLE_DIV - 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_req  = 2'd1;
  localparam logic [1:0] c_st_wait = 2'd2;

  // Per-channel address range lookup
  function automatic logic [ROM_AW-1:0] ch_start(input logic [1:0] n);
    case (n)
      2'd0:    ch_start = CH0_START;
      2'd1:    ch_start = CH1_START;
      default: ch_start = CH2_START;
    endcase
  endfunction

  function automatic logic [ROM_AW-1:0] ch_end(input logic [1:0] n);
    case (n)
      2'd0:    ch_end = CH0_END;
      2'd1:    ch_end = CH1_END;
      default: ch_end = CH2_END;
    endcase
  endfunction

  logic [2:0]         r_ctrl_q;
  logic [2:0]         r_active;
  logic [2:0]         r_pending;
  logic [ROM_AW-1:0]  r_ptr [3];
  logic [c_div_w-1:0] r_div;
  logic [1:0]         r_state;
  logic [1:0]         r_grant;
  logic               r_discard;
  logic [ROM_AW-1:0]  r_addr;
  logic signed [15:0] r_ds [3];
  logic               r_overrun;

  logic [1:0]         w_state_nxt;
  logic [2:0]         w_trig;
  logic               w_tick;
  logic               w_ack;
  logic               w_discard_now;
  logic [2:0]         w_grant_oh;
  logic [2:0]         w_active_nxt;
  logic [2:0]         w_pend_base;
  logic [2:0]         w_pend_nxt;
  logic [ROM_AW-1:0]  w_ptr_nxt [3];
  logic               w_overrun_evt;
  logic [1:0]         w_sel;
  logic               w_start_fetch;
  logic signed [15:0] w_samp;
  logic signed [15:0] w_gain;
  logic signed [15:0] w_scaled;

  assign w_trig        = I_SND_CTRL & ~r_ctrl_q;
  assign w_tick        = (r_div == c_div_last);
  assign w_ack         = (r_state == c_st_wait) && I_ROM_ACK;
  // A retrigger of the granted channel at any point of its fetch voids that fetch
  assign w_discard_now = r_discard || w_trig[r_grant];
  assign w_grant_oh    = 3'b001 << r_grant;

  // Offset-binary to two's complement, then scale by volume*16 (always fits in 16 bits)
  assign w_samp   = {{8{~I_ROM_DATA[7]}}, ~I_ROM_DATA[7], I_ROM_DATA[6:0]};
  assign w_gain   = {8'd0, I_ANLG_VOL, 4'd0};
  assign w_scaled = w_samp * w_gain;

  // Channel bookkeeping: triggers restart, acks advance or stop, tick re-arms pending
  always_comb begin
    w_active_nxt = r_active | w_trig;
    w_pend_base  = r_pending & ~w_trig;
    for (int n = 0; n < 3; n++) begin
      w_ptr_nxt[n] = w_trig[n] ? ch_start(2'(n)) : r_ptr[n];
    end
    if (w_ack) begin
      w_pend_base = w_pend_base & ~w_grant_oh;
      if (!w_discard_now) begin
        if (r_ptr[r_grant] == ch_end(r_grant)) begin
`ifdef MARIO_SAMPLE_LOOP_EN
          if (I_SND_CTRL[r_grant]) begin
            w_ptr_nxt[r_grant] = ch_start(r_grant);
          end else begin
            w_active_nxt[r_grant] = 1'b0;
          end
`else
          w_active_nxt[r_grant] = 1'b0;
`endif
        end else begin
          w_ptr_nxt[r_grant] = r_ptr[r_grant] + 1'b1;
        end
      end
    end
    w_pend_nxt    = w_tick ? (w_pend_base | w_active_nxt) : w_pend_base;
    w_overrun_evt = w_tick && (|(w_pend_base & r_active));
  end

  // Fixed priority: lowest pending channel index wins the ROM port
  always_comb begin
    if (w_pend_nxt[0]) begin
      w_sel = 2'd0;
    end else if (w_pend_nxt[1]) begin
      w_sel = 2'd1;
    end else begin
      w_sel = 2'd2;
    end
  end

  // Arbiter state register
  always_ff @(posedge I_CLK_12M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Arbiter next state; IDLE looks at next-pending so a tick requests one cycle later
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (w_pend_nxt != 3'b000) w_state_nxt = c_st_req;
      c_st_req:  w_state_nxt = c_st_wait;
      c_st_wait: if (I_ROM_ACK) w_state_nxt = c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  assign w_start_fetch = (r_state == c_st_idle) && (w_state_nxt == c_st_req);

  // Arbiter outputs
  always_comb begin
    O_ROM_REQ = (r_state != c_st_idle);
  end

  // Divider, channel state, grant/address capture, sample outputs and overrun flag
  always_ff @(posedge I_CLK_12M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      r_ctrl_q  <= 3'b000;
      r_active  <= 3'b000;
      r_pending <= 3'b000;
      r_div     <= '0;
      r_grant   <= 2'd0;
      r_discard <= 1'b0;
      r_addr    <= '0;
      r_overrun <= 1'b0;
      for (int n = 0; n < 3; n++) begin
        r_ptr[n] <= '0;
        r_ds[n]  <= '0;
      end
    end else begin
      r_ctrl_q  <= I_SND_CTRL;
      r_active  <= w_active_nxt;
      r_pending <= w_pend_nxt;
      r_div     <= w_tick ? '0 : r_div + 1'b1;
      for (int n = 0; n < 3; n++) begin
        r_ptr[n] <= w_ptr_nxt[n];
        if (w_tick && !r_active[n]) begin
          r_ds[n] <= '0;
        end
      end
      if (w_ack && !w_discard_now) begin
        r_ds[r_grant] <= w_scaled;
      end
      // Address comes from next-pointer so a same-cycle trigger fetches START
      if (w_start_fetch) begin
        r_grant <= w_sel;
        r_addr  <= w_ptr_nxt[w_sel];
      end
      if (r_state == c_st_idle) begin
        r_discard <= 1'b0;
      end else if (w_trig[r_grant]) begin
        r_discard <= 1'b1;
      end
      if (w_overrun_evt) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign O_ROM_ADDR   = r_addr;
  assign O_WAVROM_DS0 = r_ds[0];
  assign O_WAVROM_DS1 = r_ds[1];
  assign O_WAVROM_DS2 = r_ds[2];
  assign O_ACTIVE     = r_active;
  assign O_OVERRUN    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_mario_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_mario_sample_scheduler
// Purpose  : Self-checking bench for mario_sample_scheduler: reset, table of
//            single-channel samples, arbitration order, retrigger in flight,
//            loop/stop at end, random traffic against a per-period model,
//            overrun and reset mid-fetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mario_sample_scheduler;

  localparam int        SD = 16;
  localparam logic [15:0] S0 = 16'h0000, E0 = 16'h0003;
  localparam logic [15:0] S1 = 16'h1000, E1 = 16'h1003;
  localparam logic [15:0] S2 = 16'h2000, E2 = 16'h2003;
`ifdef MARIO_SAMPLE_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  typedef struct {
    logic [7:0] d;
    logic [3:0] v;
    int         exp_ds;
    bit         exp_act;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] ctrl;
  logic [3:0] vol;
  logic req;
  logic [15:0] addr;
  logic ack;
  logic [7:0] data;
  logic signed [15:0] ds0, ds1, ds2;
  logic [2:0] active;
  logic overrun;

  int checks = 0;
  int errors = 0;
  int cyc;
  int ack_lat = 1;
  bit ack_toggle = 1'b0;
  int stray_req = 0;
  logic [15:0] fetched[$];
  logic [15:0] eq[$];
  logic [7:0] rom_mem[int];

  always #5 clk = ~clk;

  mario_sample_scheduler #(
    .SAMPLE_DIV(SD), .ROM_AW(16),
    .CH0_START(S0), .CH0_END(E0),
    .CH1_START(S1), .CH1_END(E1),
    .CH2_START(S2), .CH2_END(E2)
  ) dut (
    .I_CLK_12M(clk), .I_RESETn(rst_n), .I_SND_CTRL(ctrl), .I_ANLG_VOL(vol),
    .O_ROM_REQ(req), .O_ROM_ADDR(addr), .I_ROM_ACK(ack), .I_ROM_DATA(data),
    .O_WAVROM_DS0(ds0), .O_WAVROM_DS1(ds1), .O_WAVROM_DS2(ds2),
    .O_ACTIVE(active), .O_OVERRUN(overrun)
  );

  // Edges since reset release; the tick is consumed on every edge where cyc%SD==0
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [7:0] rom_rd(input logic [15:0] a);
    if (rom_mem.exists(int'(a))) return rom_mem[int'(a)];
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic int scale(input logic [7:0] d, input logic [3:0] v);
    return (int'(d) - 128) * int'(v) * 16;
  endfunction

  function automatic logic [15:0] m_start(input int n);
    return (n == 0) ? S0 : (n == 1) ? S1 : S2;
  endfunction

  function automatic logic [15:0] m_end(input int n);
    return (n == 0) ? E0 : (n == 1) ? E1 : E2;
  endfunction

  function automatic string qstr(input logic [15:0] q[$]);
    string s;
    s = "";
    foreach (q[i]) s = {s, $sformatf("%h ", q[i])};
    return s;
  endfunction

  // ROM responder: acks ack_lat cycles after the request is seen, one-cycle pulse
  initial begin
    int wcnt;
    int stray_done;
    bit tg;
    wcnt = 0; stray_done = 0; tg = 1'b0;
    ack = 1'b0; data = 8'h00;
    forever begin
      @(posedge clk); #1;
      ack = 1'b0;
      if (ack_toggle) begin
        tg = ~tg; ack = tg; data = 8'hFF;
      end else if (stray_req != stray_done) begin
        stray_done++; ack = 1'b1; data = 8'hFF;
      end else if (req) begin
        if (wcnt >= ack_lat) begin
          ack = 1'b1; data = rom_rd(addr); fetched.push_back(addr); wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_fetch(input string name);
    bit ok;
    ok = (fetched.size() == eq.size());
    if (ok) foreach (eq[i]) if (fetched[i] !== eq[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got addrs [%s] expected [%s] (t=%0t)", name, qstr(fetched), qstr(eq), $time);
    end
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < SD; i++) begin
      step();
      if (cyc % SD == p) return;
    end
    checks++; errors++;
    $display("FAIL wait_phase: phase %0d not reached", p);
  endtask

  task automatic do_reset();
    ctrl = 3'b000; rst_n = 1'b0;
    repeat (3) step();
    ack_lat = 1;
    @(posedge clk); #3;
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t tbl[8];
    bit [2:0] m_act, mprev, nc;
    logic [15:0] m_ptr[3];
    int m_out[3];
    int reqcnt;
    logic [3:0] nv;

    tbl[0] = '{8'h80, 4'd15,      0, 1'b1};
    tbl[1] = '{8'hFF, 4'd15,  30480, 1'b1};
    tbl[2] = '{8'h00, 4'd15, -30720, 1'b1};
    tbl[3] = '{8'h90, 4'd15,   3840, 1'b0};
    tbl[4] = '{8'h7F, 4'd1,     -16, 1'b1};
    tbl[5] = '{8'h01, 4'd7,  -14224, 1'b1};
    tbl[6] = '{8'hC3, 4'd0,       0, 1'b1};
    tbl[7] = '{8'hFF, 4'd8,   16256, 1'b0};

    // Reset held with a toggling ack
    rst_n = 1'b0; ctrl = 3'b000; vol = 4'd15;
    ack_toggle = 1'b1;
    repeat (6) step();
    chk("rst_req", int'(req), 0);
    chk("rst_ds0", int'(ds0), 0);
    chk("rst_ds1", int'(ds1), 0);
    chk("rst_ds2", int'(ds2), 0);
    chk("rst_active", int'(active), 0);
    chk("rst_overrun", int'(overrun), 0);
    ack_toggle = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    reqcnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (req) reqcnt++;
    end
    chk("idle_no_req", reqcnt, 0);

    // Single channel table: CH0 four samples, two passes
    wait_phase(14);
    for (int i = 0; i < 8; i++) begin
      if (i % 4 == 0) ctrl[0] = 1'b1;
      rom_mem[int'(S0) + (i % 4)] = tbl[i].d;
      vol = tbl[i].v;
      fetched.delete();
      step();
      ctrl[0] = 1'b0;
      wait_phase(14);
      chk("tbl_ds0", int'(ds0), tbl[i].exp_ds);
      chk("tbl_active0", int'(active[0]), int'(tbl[i].exp_act));
      eq.delete(); eq.push_back(S0 + 16'(i % 4));
      chk_fetch("tbl_addr");
    end
    fetched.delete();
    wait_phase(14);
    chk("tbl_ds0_zero", int'(ds0), 0);
    eq.delete();
    chk_fetch("tbl_no_fetch");

    // Arbitration order within one period
    do_reset();
    vol = 4'd15;
    rom_mem[int'(S0)] = 8'h11; rom_mem[int'(S1)] = 8'hE0; rom_mem[int'(S2)] = 8'h85;
    wait_phase(14);
    ctrl = 3'b111; fetched.delete();
    step();
    ctrl = 3'b000;
    wait_phase(14);
    eq.delete(); eq.push_back(S0); eq.push_back(S1); eq.push_back(S2);
    chk_fetch("arb_order");
    chk("arb_ds0", int'(ds0), scale(8'h11, 4'd15));
    chk("arb_ds1", int'(ds1), scale(8'hE0, 4'd15));
    chk("arb_ds2", int'(ds2), scale(8'h85, 4'd15));

    // Retrigger of CH1 while its fetch is in WAIT
    do_reset();
    ack_lat = 3; vol = 4'd9;
    rom_mem[int'(S1)] = 8'hA0; rom_mem[int'(S1) + 1] = 8'h20;
    wait_phase(14);
    ctrl[1] = 1'b1; fetched.delete();
    step();
    ctrl[1] = 1'b0;
    wait_phase(14);
    eq.delete(); eq.push_back(S1);
    chk_fetch("rt_first");
    chk("rt_ds1_first", int'(ds1), scale(8'hA0, 4'd9));
    rom_mem[int'(S1)] = 8'h10;
    fetched.delete();
    wait_phase(15);
    chk("rt_no_req_before_tick", int'(req), 0);
    wait_phase(0);
    chk("rt_req_after_tick", int'(req), 1);
    chk("rt_addr", int'(addr), int'(S1) + 1);
    wait_phase(2);
    ctrl[1] = 1'b1;
    step();
    ctrl[1] = 1'b0;
    wait_phase(14);
    eq.delete(); eq.push_back(S1 + 16'd1);
    chk_fetch("rt_inflight");
    chk("rt_ds1_kept", int'(ds1), scale(8'hA0, 4'd9));
    chk("rt_active1", int'(active[1]), 1);
    fetched.delete();
    wait_phase(14);
    eq.delete(); eq.push_back(S1);
    chk_fetch("rt_restart");
    chk("rt_ds1_restart", int'(ds1), scale(8'h10, 4'd9));

    // CH2 held high through its end address
    do_reset();
    wait_phase(14);
    ctrl[2] = 1'b1;
    for (int j = 0; j < 5; j++) begin
      fetched.delete();
      wait_phase(14);
      eq.delete();
      if (j < 4) eq.push_back(S2 + 16'(j));
      else if (LOOP) eq.push_back(S2);
      chk_fetch("loop_addr");
      chk("loop_active2", int'(active[2]), (j < 3 || LOOP) ? 1 : 0);
    end
    ctrl[2] = 1'b0;

    // Random traffic against a per-period model
    do_reset();
    for (int a = 0; a < 4; a++) begin
      rom_mem[int'(S0) + a] = 8'($urandom);
      rom_mem[int'(S1) + a] = 8'($urandom);
      rom_mem[int'(S2) + a] = 8'($urandom);
    end
    m_act = 3'b000; mprev = 3'b000;
    for (int n = 0; n < 3; n++) begin m_ptr[n] = 16'h0000; m_out[n] = 0; end
    wait_phase(14);
    for (int k = 0; k < 80; k++) begin
      nc = 3'($urandom_range(0, 7));
      nv = 4'($urandom_range(0, 15));
      ack_lat = $urandom_range(1, 3);
      vol = nv;
      fetched.delete();
      if ($urandom_range(0, 1) == 1) step();
      ctrl = nc;
      for (int n = 0; n < 3; n++) begin
        if (nc[n] && !mprev[n]) begin m_act[n] = 1'b1; m_ptr[n] = m_start(n); end
      end
      mprev = nc;
      eq.delete();
      for (int n = 0; n < 3; n++) if (!m_act[n]) m_out[n] = 0;
      for (int n = 0; n < 3; n++) begin
        if (m_act[n]) begin
          eq.push_back(m_ptr[n]);
          m_out[n] = scale(rom_rd(m_ptr[n]), nv);
          if (m_ptr[n] == m_end(n)) begin
            if (LOOP && nc[n]) m_ptr[n] = m_start(n);
            else m_act[n] = 1'b0;
          end else begin
            m_ptr[n] = m_ptr[n] + 16'd1;
          end
        end
      end
      wait_phase(14);
      chk_fetch("rnd_addr");
      chk("rnd_ds0", int'(ds0), m_out[0]);
      chk("rnd_ds1", int'(ds1), m_out[1]);
      chk("rnd_ds2", int'(ds2), m_out[2]);
      chk("rnd_active", int'(active), int'(m_act));
    end
    chk("rnd_no_overrun", int'(overrun), 0);

    // Overrun with a slow ROM, then reset mid-fetch and a stray ack
    do_reset();
    ack_lat = 20; vol = 4'd15;
    wait_phase(14);
    ctrl[0] = 1'b1; fetched.delete();
    step();
    ctrl[0] = 1'b0;
    for (int j = 0; j < 4; j++) wait_phase(14);
    chk("ovr_flag", int'(overrun), 1);
    eq.delete(); eq.push_back(S0); eq.push_back(S0 + 16'd1);
    chk_fetch("ovr_no_dup");
    wait_phase(2);
    chk("ovr_req_inflight", int'(req), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_req", int'(req), 0);
    chk("rst_mid_overrun", int'(overrun), 0);
    step();
    @(posedge clk); #3;
    rst_n = 1'b1;
    stray_req++;
    repeat (4) step();
    chk("stray_ack_ds0", int'(ds0), 0);
    chk("stray_ack_req", int'(req), 0);
    chk("stray_ack_active", int'(active), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
